// File: rtl/checksum_frame_tx_pkg.sv
// Shared definitions for the checksummed link transmitter.
//   PAYLOAD_W / CHK_W / FRAME_W / NIBBLES : frame geometry, {payload, chk}
//   tx_state_t                            : transmitter FSM encoding
//   nibble_at()                           : nibble idx of a frame (idx 6 = MSB nibble)
package checksum_frame_tx_pkg;

  localparam int PAYLOAD_W = 24;
  localparam int CHK_W     = 4;
  localparam int FRAME_W   = 28;
  localparam int NIBBLES   = 7;

  localparam logic [2:0] NIB_FIRST = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2
  } tx_state_t;

  function automatic logic [3:0] nibble_at(input logic [FRAME_W-1:0] frame,
                                           input logic [2:0]         idx);
    logic [FRAME_W-1:0] sh;
    sh = frame >> {idx, 2'b00};
    return sh[3:0];
  endfunction

endpackage

// File: rtl/checksum_frame_tx_encoder.sv
// Combinational frame encoder, shared with the receive-side decoder so both
// ends compute the checksum identically.
//   payload : 24-bit payload
//   frame   : {payload, chk}, chk = XOR of the six payload nibbles
module checksum_frame_tx_encoder
  import checksum_frame_tx_pkg::*;
(
  input  logic [PAYLOAD_W-1:0] payload,
  output logic [FRAME_W-1:0]   frame
);

  logic [CHK_W-1:0] chk;

  always_comb begin
    chk = '0;
    for (int i = 0; i < PAYLOAD_W / CHK_W; i++) begin
      chk = chk ^ payload[i*CHK_W +: CHK_W];
    end
  end

  assign frame = {payload, chk};

endmodule

// File: rtl/checksum_frame_tx.sv
// Transmit end of the checksummed link. Latches a payload, appends a 4-bit
// XOR checksum and serialises the 28-bit frame as 7 nibbles, MSB first.
// Holds the frame until ack; resends on nack or response timeout, and drops
// it after MAX_RETRY failed resends.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_payload/in_valid : payload offer, accepted when in_ready (IDLE only)
//   in_ready            : block idle
//   tx_nibble/tx_valid  : registered nibble stream, tx_sof marks frame[27:24]
//   rsp_valid/rsp_ack   : receiver response strobe, 1=ack 0=nack
//   sent_ok / drop_err  : 1-cycle completion pulses
module checksum_frame_tx
  import checksum_frame_tx_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int RSP_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           tx_nibble,
  output logic                 tx_valid,
  output logic                 tx_sof,
  input  logic                 rsp_valid,
  input  logic                 rsp_ack,
  output logic                 sent_ok,
  output logic                 drop_err
);

  // MAX_RETRY=0 still needs a one-bit counter to hold zero.
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  tx_state_t            state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d, enc_frame;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [2:0]           nib_q, nib_d;
  logic [3:0]           nibble_d;
  logic                 valid_d, sof_d, sent_d, drop_d;
  logic                 fail;

  checksum_frame_tx_encoder u_enc (
    .payload (in_payload),
    .frame   (enc_frame)
  );

  assign in_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    nib_d    = nib_q;
    nibble_d = 4'h0;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    sent_d   = 1'b0;
    drop_d   = 1'b0;
    fail     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The first nibble is registered on the accept edge itself.
        if (in_valid) begin
          frame_d  = enc_frame;
          retry_d  = '0;
          nib_d    = NIB_FIRST;
          nibble_d = nibble_at(enc_frame, NIB_FIRST);
          valid_d  = 1'b1;
          sof_d    = 1'b1;
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        // nib_q is the nibble on the wire this cycle; load the next one.
        if (nib_q == 3'd0) begin
          timer_d = '0;
          state_d = ST_WAIT_RSP;
        end else begin
          nib_d    = nib_q - 3'd1;
          nibble_d = nibble_at(frame_q, nib_q - 3'd1);
          valid_d  = 1'b1;
        end
      end

      ST_WAIT_RSP: begin
        timer_d = timer_q + CNT_W'(1);
        // A response on the timeout cycle takes precedence over the timeout.
        if (rsp_valid && rsp_ack) begin
          sent_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (rsp_valid || (timer_q == CNT_W'(RSP_TIMEOUT - 1))) begin
          fail = 1'b1;
        end

        if (fail) begin
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            retry_d  = retry_q + RETRY_W'(1);
            nib_d    = NIB_FIRST;
            nibble_d = nibble_at(frame_q, NIB_FIRST);
            valid_d  = 1'b1;
            sof_d    = 1'b1;
            state_d  = ST_SEND;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      nib_q     <= NIB_FIRST;
      tx_nibble <= 4'h0;
      tx_valid  <= 1'b0;
      tx_sof    <= 1'b0;
      sent_ok   <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      nib_q     <= nib_d;
      tx_nibble <= nibble_d;
      tx_valid  <= valid_d;
      tx_sof    <= sof_d;
      sent_ok   <= sent_d;
      drop_err  <= drop_d;
    end
  end

endmodule

// File: tb/tb_checksum_frame_tx.sv
module tb_checksum_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_payload;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  tx_nibble;
  logic        tx_valid;
  logic        tx_sof;
  logic        rsp_valid;
  logic        rsp_ack;
  logic        sent_ok;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  checksum_frame_tx #(.MAX_RETRY(3), .RSP_TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_payload (in_payload),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_nibble  (tx_nibble),
    .tx_valid   (tx_valid),
    .tx_sof     (tx_sof),
    .rsp_valid  (rsp_valid),
    .rsp_ack    (rsp_ack),
    .sent_ok    (sent_ok),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Starts on the negedge where the first nibble should be visible; ends on
  // the negedge of the first WAIT_RSP cycle.
  task automatic check_frame(input logic [27:0] f, input bit spur, input string tag);
    logic [27:0] t;
    for (int i = 0; i < 7; i++) begin
      t = f >> (4 * (6 - i));
      chk_eq({tag, "_vld"}, 32'(tx_valid), 32'd1);
      chk_eq({tag, "_nib"}, 32'(tx_nibble), 32'(t[3:0]));
      chk_eq({tag, "_sof"}, 32'(tx_sof), 32'(i == 0));
      if (spur) begin
        rsp_valid = (i == 2);
        rsp_ack   = 1'b0;
      end
      tick();
    end
    chk_eq({tag, "_wait_vld"}, 32'(tx_valid), 32'd0);
    chk_eq({tag, "_wait_rdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic offer(input logic [23:0] p);
    in_payload = p;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic ack_now(input string tag);
    rsp_valid = 1'b1;
    rsp_ack   = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    chk_eq({tag, "_sent"}, 32'(sent_ok), 32'd1);
    chk_eq({tag, "_drop"}, 32'(drop_err), 32'd0);
    chk_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk_eq({tag, "_novld"}, 32'(tx_valid), 32'd0);
    tick();
    chk_eq({tag, "_sent_end"}, 32'(sent_ok), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_payload = 24'h0;
    in_valid   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_ack    = 1'b0;
    tick();
    tick();
    chk_eq("rst_rdy", 32'(in_ready), 32'd1);
    chk_eq("rst_vld", 32'(tx_valid), 32'd0);
    chk_eq("rst_nib", 32'(tx_nibble), 32'd0);
    chk_eq("rst_sof", 32'(tx_sof), 32'd0);
    chk_eq("rst_sent", 32'(sent_ok), 32'd0);
    chk_eq("rst_drop", 32'(drop_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: 0x123456, chk 1^2^3^4^5^6 = 7; ack on WAIT_RSP cycle 3
    chk_eq("t1_rdy", 32'(in_ready), 32'd1);
    offer(24'h123456);
    check_frame(28'h1234567, 1'b0, "t1");
    tick();
    tick();
    ack_now("t1");

    // 2: 0xABCDEF, chk A^B^C^D^E^F = 1; nack then ack
    offer(24'hABCDEF);
    check_frame(28'hABCDEF1, 1'b0, "t2a");
    rsp_valid = 1'b1;
    rsp_ack   = 1'b0;
    tick();
    rsp_valid = 1'b0;
    chk_eq("t2_nack_drop", 32'(drop_err), 32'd0);
    check_frame(28'hABCDEF1, 1'b0, "t2b");
    ack_now("t2");

    // 3: 0x0F1E2D, chk 0^F^1^E^2^D = F; never answered -> 4 sends then drop
    offer(24'h0F1E2D);
    check_frame(28'h0F1E2DF, 1'b0, "t3s0");
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) begin
        chk_eq("t3_idle_vld", 32'(tx_valid), 32'd0);
        chk_eq("t3_idle_drop", 32'(drop_err), 32'd0);
        tick();
      end
      if (r < 3) begin
        check_frame(28'h0F1E2DF, 1'b0, "t3rs");
      end else begin
        chk_eq("t3_drop", 32'(drop_err), 32'd1);
        chk_eq("t3_sent", 32'(sent_ok), 32'd0);
        chk_eq("t3_rdy", 32'(in_ready), 32'd1);
        chk_eq("t3_novld", 32'(tx_valid), 32'd0);
        tick();
        chk_eq("t3_drop_end", 32'(drop_err), 32'd0);
      end
    end

    // 4: 0x000001, chk 1; spurious nack during SEND, ack on the timeout cycle
    offer(24'h000001);
    check_frame(28'h0000011, 1'b1, "t4");
    for (int k = 0; k < 15; k++) tick();
    chk_eq("t4_pre_to_vld", 32'(tx_valid), 32'd0);
    ack_now("t4");
    chk_eq("t4_no_resend", 32'(tx_valid), 32'd0);

    // 5: reset on the 3rd nibble of 0xFFFFFF, then send 0x000000
    in_payload = 24'hFFFFFF;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("t5_nib", 32'(tx_nibble), 32'hF);
      if (i < 2) tick();
    end
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_vld", 32'(tx_valid), 32'd0);
    chk_eq("t5_rst_nib", 32'(tx_nibble), 32'd0);
    chk_eq("t5_rst_sof", 32'(tx_sof), 32'd0);
    chk_eq("t5_rst_rdy", 32'(in_ready), 32'd1);
    chk_eq("t5_rst_drop", 32'(drop_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_eq("t5_post_drop", 32'(drop_err), 32'd0);
    offer(24'h000000);
    check_frame(28'h0000000, 1'b0, "t5");
    ack_now("t5");

    // 6: in_valid held across a whole transaction; 0x111111 (chk 0) then 0x222220 (chk 2)
    in_payload = 24'h111111;
    in_valid   = 1'b1;
    tick();
    in_payload = 24'h222220;
    check_frame(28'h1111110, 1'b0, "t6a");
    rsp_valid = 1'b1;
    rsp_ack   = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    chk_eq("t6_sent", 32'(sent_ok), 32'd1);
    chk_eq("t6_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_frame(28'h2222202, 1'b0, "t6b");
    ack_now("t6");
    for (int k = 0; k < 4; k++) begin
      chk_eq("t6_no_dup", 32'(tx_valid), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
